// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, sequences fixed-latency instruction
// memory reads and presents the captured instruction with its PC and PC+4.
module instr_fetch_unit #(
   parameter logic [63:0] RESET_PC    = 64'h0,
   parameter int          MEM_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_req,
   input  logic        pc_write,
   input  logic [63:0] pc_in,
   output logic [63:0] mem_addr,
   output logic        mem_read,
   input  logic [31:0] mem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [63:0] instr_pc,
   output logic [63:0] instr_pc4,
   output logic        busy,
   output logic        fetch_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      WAIT  = 2'd2,
      VALID = 2'd3
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

   state_t      state_r;
   logic [63:0] pc_r;
   logic [3:0]  cnt_r;
   logic        pendValid_r;
   logic [63:0] pendTgt_r;

   logic [63:0] fetchAddr_s;
   logic [63:0] pcPlus4_s;
   logic [63:0] capturePc_s;

   // Fetch address, sequential PC and the PC to resume from after capture.
   // A redirect arriving on the capture edge itself is the newest one and wins.
   always_comb begin
      fetchAddr_s = pc_r;
      capturePc_s = pc_r;
      pcPlus4_s   = pc_r + 64'd4;
      if (pc_write) begin
         fetchAddr_s = pc_in;
         capturePc_s = pc_in;
      end else if (pendValid_r) begin
         capturePc_s = pendTgt_r;
      end else begin
         capturePc_s = pcPlus4_s;
      end
   end

   // Fetch sequencer with registered memory strobe and status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         pc_r        <= RESET_PC;
         cnt_r       <= 4'd0;
         pendValid_r <= 1'b0;
         pendTgt_r   <= 64'd0;
         mem_addr    <= 64'd0;
         mem_read    <= 1'b0;
         instr       <= 32'd0;
         instr_valid <= 1'b0;
         instr_pc    <= 64'd0;
         instr_pc4   <= 64'd0;
         busy        <= 1'b0;
         fetch_err   <= 1'b0;
      end else begin
         fetch_err <= 1'b0;
         case (state_r)
            IDLE, VALID: begin
               if (fetch_req) begin
                  pc_r        <= fetchAddr_s;
                  instr_valid <= 1'b0;
                  if (fetchAddr_s[1:0] != 2'b00) begin
                     // Misaligned: refuse without touching memory.
                     fetch_err <= 1'b1;
                     state_r   <= IDLE;
                  end else begin
                     mem_addr <= fetchAddr_s;
                     mem_read <= 1'b1;
                     busy     <= 1'b1;
                     cnt_r    <= CNT_INIT;
                     state_r  <= REQ;
                  end
               end else if (pc_write) begin
                  pc_r <= pc_in;
               end
            end
            REQ, WAIT: begin
               if (cnt_r == 4'd0) begin
                  instr       <= mem_rdata;
                  instr_pc    <= pc_r;
                  instr_pc4   <= pcPlus4_s;
                  pc_r        <= capturePc_s;
                  pendValid_r <= 1'b0;
                  instr_valid <= 1'b1;
                  mem_read    <= 1'b0;
                  busy        <= 1'b0;
                  state_r     <= VALID;
               end else begin
                  cnt_r   <= cnt_r - 4'd1;
                  state_r <= WAIT;
                  if (pc_write) begin
                     pendValid_r <= 1'b1;
                     pendTgt_r   <= pc_in;
                  end
               end
            end
            default: begin
               state_r  <= IDLE;
               mem_read <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: one instance at latency 1, one at
// latency 3, each fed by a latency-aware instruction memory model.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst, fetch_req, pc_write;
   logic [63:0] pc_in;
   logic        useL3;

   logic [63:0] a_addr, a_ipc, a_ipc4, b_addr, b_ipc, b_ipc4;
   logic        a_read, a_valid, a_busy, a_err, b_read, b_valid, b_busy, b_err;
   logic [31:0] a_rdata, a_instr, b_rdata, b_instr;
   int          a_rc = 0, b_rc = 0;

   logic [63:0] o_addr, o_ipc, o_ipc4;
   logic        o_read, o_valid, o_busy, o_err;
   logic [31:0] o_instr;

   typedef struct packed {
      logic [63:0] addr;
      logic [31:0] word;
   } exp_t;
   exp_t sbq[$];

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   instr_fetch_unit #(.RESET_PC(64'h0), .MEM_LATENCY(1)) dut1 (
      .clk(clk), .rst(rst), .fetch_req(fetch_req), .pc_write(pc_write), .pc_in(pc_in),
      .mem_addr(a_addr), .mem_read(a_read), .mem_rdata(a_rdata), .instr(a_instr),
      .instr_valid(a_valid), .instr_pc(a_ipc), .instr_pc4(a_ipc4), .busy(a_busy),
      .fetch_err(a_err));

   instr_fetch_unit #(.RESET_PC(64'h0), .MEM_LATENCY(3)) dut3 (
      .clk(clk), .rst(rst), .fetch_req(fetch_req), .pc_write(pc_write), .pc_in(pc_in),
      .mem_addr(b_addr), .mem_read(b_read), .mem_rdata(b_rdata), .instr(b_instr),
      .instr_valid(b_valid), .instr_pc(b_ipc), .instr_pc4(b_ipc4), .busy(b_busy),
      .fetch_err(b_err));

   function automatic logic [31:0] memword(input logic [63:0] a);
      if (a == 64'h0) return 32'h0050_0093;
      return a[31:0] ^ 32'h1357_9BDF;
   endfunction

   // Memory returns valid data only in the last cycle of each read.
   always @(posedge clk) begin
      a_rc <= a_read ? a_rc + 1 : 0;
      b_rc <= b_read ? b_rc + 1 : 0;
   end
   assign a_rdata = (a_read && a_rc == 0) ? memword(a_addr) : 32'hDEAD_BEEF;
   assign b_rdata = (b_read && b_rc == 2) ? memword(b_addr) : 32'hDEAD_BEEF;

   assign o_addr  = useL3 ? b_addr  : a_addr;
   assign o_ipc   = useL3 ? b_ipc   : a_ipc;
   assign o_ipc4  = useL3 ? b_ipc4  : a_ipc4;
   assign o_read  = useL3 ? b_read  : a_read;
   assign o_valid = useL3 ? b_valid : a_valid;
   assign o_busy  = useL3 ? b_busy  : a_busy;
   assign o_err   = useL3 ? b_err   : a_err;
   assign o_instr = useL3 ? b_instr : a_instr;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; fetch_req = 1'b0; pc_write = 1'b0; pc_in = 64'h0;
      tick(); tick();
      rst = 1'b0;
      sbq.delete();
   endtask

   // Issue one fetch, watch the read strobe, then pop and compare the capture.
   task automatic fetch_and_check(input logic [63:0] expAddr, input bit redir,
                                  input logic [63:0] tgt, input bit midRedir,
                                  input logic [63:0] midTgt, input int lat);
      exp_t e;
      int n = 0;
      fetch_req = 1'b1; pc_write = redir; pc_in = tgt;
      e.addr = expAddr; e.word = memword(expAddr);
      sbq.push_back(e);
      tick();
      fetch_req = 1'b0; pc_write = 1'b0;
      while (o_read === 1'b1 && n < 20) begin
         vectors++;
         if (o_addr !== expAddr || o_busy !== 1'b1 || o_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL read_phase: addr=%h busy=%b valid=%b expected addr=%h busy=1 valid=0",
                     o_addr, o_busy, o_valid, expAddr);
         end
         n++;
         if (midRedir && n == 2) begin
            pc_write = 1'b1; pc_in = midTgt;
         end
         tick();
         pc_write = 1'b0;
      end
      vectors++;
      if (n !== lat) begin
         miscompares++;
         $display("FAIL read_cycles: got %0d expected %0d", n, lat);
      end
      vectors++;
      if (o_valid !== 1'b1 || o_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL valid_after_read: valid=%b busy=%b expected valid=1 busy=0", o_valid, o_busy);
      end
      vectors++;
      if (sbq.size() == 0) begin
         miscompares++;
         $display("FAIL scoreboard_empty: got 0 entries expected 1");
      end else begin
         e = sbq.pop_front();
         if (o_instr !== e.word || o_ipc !== e.addr || o_ipc4 !== e.addr + 64'd4) begin
            miscompares++;
            $display("FAIL capture: instr=%h pc=%h pc4=%h expected instr=%h pc=%h pc4=%h",
                     o_instr, o_ipc, o_ipc4, e.word, e.addr, e.addr + 64'd4);
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      for (int s = 0; s < 2; s++) begin
         useL3 = (s == 1);
         #0;
         vectors++;
         if ({o_read, o_busy, o_valid, o_err} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b expected 0000", {o_read, o_busy, o_valid, o_err});
         end
         vectors++;
         if (o_instr !== 32'h0 || o_ipc !== 64'h0 || o_ipc4 !== 64'h0 || o_addr !== 64'h0) begin
            miscompares++;
            $display("FAIL reset_regs: instr=%h pc=%h pc4=%h addr=%h expected all 0",
                     o_instr, o_ipc, o_ipc4, o_addr);
         end
      end
   endtask

   task automatic test_single_fetch();
      do_reset(); useL3 = 1'b0;
      fetch_and_check(64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 1);
      fetch_and_check(64'h4, 1'b0, 64'h0, 1'b0, 64'h0, 1);
   endtask

   task automatic test_back_to_back();
      do_reset(); useL3 = 1'b1;
      fetch_and_check(64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 3);
      fetch_and_check(64'h4, 1'b0, 64'h0, 1'b0, 64'h0, 3);
      fetch_and_check(64'h8, 1'b0, 64'h0, 1'b0, 64'h0, 3);
      fetch_and_check(64'hC, 1'b0, 64'h0, 1'b0, 64'h0, 3);
   endtask

   task automatic test_redirect_idle();
      do_reset(); useL3 = 1'b0;
      fetch_and_check(64'h100, 1'b1, 64'h100, 1'b0, 64'h0, 1);
      fetch_and_check(64'h104, 1'b0, 64'h0, 1'b0, 64'h0, 1);
   endtask

   task automatic test_redirect_mid_read();
      do_reset(); useL3 = 1'b1;
      fetch_and_check(64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 3);
      fetch_and_check(64'h4, 1'b0, 64'h0, 1'b0, 64'h0, 3);
      fetch_and_check(64'h8, 1'b0, 64'h0, 1'b1, 64'h40, 3);
      fetch_and_check(64'h40, 1'b0, 64'h0, 1'b0, 64'h0, 3);
   endtask

   task automatic test_misaligned();
      do_reset(); useL3 = 1'b0;
      fetch_and_check(64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 1);
      pc_write = 1'b1; pc_in = 64'h22;
      tick();
      pc_write = 1'b0;
      vectors++;
      if (o_valid !== 1'b1 || o_busy !== 1'b0 || o_err !== 1'b0 || o_instr !== memword(64'h0)) begin
         miscompares++;
         $display("FAIL redirect_only: valid=%b busy=%b err=%b instr=%h expected 1 0 0 %h",
                  o_valid, o_busy, o_err, o_instr, memword(64'h0));
      end
      for (int k = 0; k < 2; k++) begin
         fetch_req = 1'b1;
         tick();
         fetch_req = 1'b0;
         vectors++;
         if (o_err !== 1'b1 || o_read !== 1'b0 || o_valid !== 1'b0 || o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL misaligned_pulse: err=%b read=%b valid=%b busy=%b expected 1 0 0 0",
                     o_err, o_read, o_valid, o_busy);
         end
         tick();
         vectors++;
         if (o_err !== 1'b0 || o_read !== 1'b0 || o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL misaligned_after: err=%b read=%b busy=%b expected 0 0 0", o_err, o_read, o_busy);
         end
      end
      fetch_and_check(64'h30, 1'b1, 64'h30, 1'b0, 64'h0, 1);
   endtask

   task automatic test_reset_mid_read();
      bit sawValid = 1'b0;
      do_reset(); useL3 = 1'b1;
      fetch_and_check(64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 3);
      fetch_req = 1'b1;
      tick();
      fetch_req = 1'b0;
      tick();
      vectors++;
      if (o_read !== 1'b1 || o_addr !== 64'h4) begin
         miscompares++;
         $display("FAIL in_wait: read=%b addr=%h expected 1 %h", o_read, o_addr, 64'h4);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      vectors++;
      if (o_read !== 1'b0 || o_instr !== 32'h0 || o_valid !== 1'b0 || o_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid_read: read=%b instr=%h valid=%b busy=%b expected 0 0 0 0",
                  o_read, o_instr, o_valid, o_busy);
      end
      for (int k = 0; k < 5; k++) begin
         tick();
         if (o_valid !== 1'b0 || o_read !== 1'b0) sawValid = 1'b1;
      end
      vectors++;
      if (sawValid) begin
         miscompares++;
         $display("FAIL aborted_capture: got activity after reset expected none");
      end
      fetch_and_check(64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 3);
   endtask

   task automatic test_wrap();
      do_reset(); useL3 = 1'b0;
      fetch_and_check(64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0, 1);
      vectors++;
      if (o_ipc4 !== 64'h0) begin
         miscompares++;
         $display("FAIL wrap_pc4: got %h expected %h", o_ipc4, 64'h0);
      end
      fetch_and_check(64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 1);
   endtask

   initial begin
      useL3 = 1'b0;
      rst = 1'b1; fetch_req = 1'b0; pc_write = 1'b0; pc_in = 64'h0;
      test_reset();
      test_single_fetch();
      test_back_to_back();
      test_redirect_idle();
      test_redirect_mid_read();
      test_misaligned();
      test_reset_mid_read();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
